// File: rtl/vms_pkg.sv
// vms_pkg: shared types and constants for the vector memory sequencer.
//   vms_state_t   : sequencer FSM states (IDLE, XFER, DONE)
//   REGION_MSB/LSB: address bits used by the memory manager's bank select
//   PERIPH_REGION : bank-select code of the peripheral region
package vms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } vms_state_t;

    localparam int unsigned REGION_MSB = 18;
    localparam int unsigned REGION_LSB = 16;
    localparam logic [2:0]  PERIPH_REGION = 3'b111;

endpackage

// File: rtl/vms_addr_gen.sv
// vms_addr_gen: lane address accumulator; replaces base + idx*step with a
// running sum so no multiplier is needed.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load the accumulator with base (command accepted)
//   advance  : add step to the accumulator (one lane transferred)
//   base     : lane 0 address
//   step     : byte distance between lanes
//   addr     : current lane address (registered, wraps mod 2^A)
module vms_addr_gen #(
    parameter int unsigned A = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  logic [A-1:0] base,
    input  logic [A-1:0] step,
    output logic [A-1:0] addr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (advance) begin
            addr <= addr + step;
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: turns one vector load/store command into LANES
// sequential byte accesses on the data memory bus.
// Build option: VMS_STRIDE_EN enables the programmable lane stride; without
// it lanes are at consecutive bytes and stride_i is ignored.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   start_i      : command strobe, sampled only in IDLE
//   is_store_i   : 1 = store, 0 = load (sampled with start_i)
//   base_addr_i  : lane 0 address
//   stride_i     : byte stride between lanes (VMS_STRIDE_EN only)
//   vec_data_i   : store vector, lane k at [k*L +: L]
//   vec_data_o   : load result, updated when a load completes
//   busy_o       : command in progress
//   done_o       : one-cycle completion pulse
//   mem_addr_o   : memory address (decoded from registered state)
//   mem_wdata_o  : memory write data (decoded from registered state)
//   mem_wren_o   : memory write enable (decoded from registered state)
//   mem_rdata_i  : memory read data, valid in the same cycle as the address
module vector_mem_sequencer
    import vms_pkg::*;
#(
    parameter int unsigned L     = 8,
    parameter int unsigned A     = 32,
    parameter int unsigned LANES = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    input  logic               is_store_i,
    input  logic [A-1:0]       base_addr_i,
    input  logic [15:0]        stride_i,
    input  logic [LANES*L-1:0] vec_data_i,
    output logic [LANES*L-1:0] vec_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [A-1:0]       mem_addr_o,
    output logic [L-1:0]       mem_wdata_o,
    output logic               mem_wren_o,
    input  logic [L-1:0]       mem_rdata_i
);

    localparam int unsigned IW = $clog2(LANES);
    localparam int unsigned VW = LANES * L;

    vms_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             store_q, store_d;
    logic [VW-1:0]    data_q, data_d;
    logic [VW-1:0]    vec_d;
    logic             busy_d, done_d;
    logic             accept;
    logic             in_xfer;
    logic [A-1:0]     step;
    logic [A-1:0]     lane_addr;

    assign accept  = (state_q == IDLE) && start_i;
    assign in_xfer = (state_q == XFER);

`ifdef VMS_STRIDE_EN
    logic [15:0] stride_q;

    // Stride is captured with the command like the other operands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= stride_i;
        end
    end

    assign step = A'(stride_q);
`else
    logic unused_stride;

    assign unused_stride = ^stride_i;
    assign step          = A'(1);
`endif

    vms_addr_gen #(.A(A)) u_addr_gen (
        .clk     (CLK),
        .rst     (RST),
        .load    (accept),
        .advance (in_xfer),
        .base    (base_addr_i),
        .step    (step),
        .addr    (lane_addr)
    );

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            vec_data_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            store_q    <= store_d;
            data_q     <= data_d;
            vec_data_o <= vec_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

    // Next-state logic. data_q holds the store vector for stores and doubles
    // as the gather buffer for loads, so vec_data_o only changes when a load
    // has fully completed.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        store_d = store_q;
        data_d  = data_q;
        vec_d   = vec_data_o;
        busy_d  = busy_o;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = XFER;
                    idx_d   = '0;
                    store_d = is_store_i;
                    data_d  = vec_data_i;
                    busy_d  = 1'b1;
                end
            end
            XFER: begin
                if (!store_q) begin
                    data_d[idx_q*L +: L] = mem_rdata_i;
                end
                if (idx_q == IW'(LANES - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!store_q) begin
                        vec_d = data_d;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus outputs decode only registered signals; reset forces state to IDLE,
    // which drops the write enable without waiting for a clock edge.
    assign mem_wren_o  = in_xfer && store_q;
    assign mem_wdata_o = mem_wren_o ? data_q[idx_q*L +: L] : '0;
    assign mem_addr_o  = in_xfer ? lane_addr : '0;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: randomized self-checking bench for
// vector_mem_sequencer against a lane-level reference model with a byte
// memory. Honours VMS_STRIDE_EN when computing expected lane addresses.
module tb_vector_mem_sequencer;

    localparam int unsigned L     = 8;
    localparam int unsigned A     = 32;
    localparam int unsigned LANES = 8;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               start_i = 1'b0;
    logic               is_store_i = 1'b0;
    logic [A-1:0]       base_addr_i = '0;
    logic [15:0]        stride_i = '0;
    logic [LANES*L-1:0] vec_data_i = '0;
    logic [LANES*L-1:0] vec_data_o;
    logic               busy_o;
    logic               done_o;
    logic [A-1:0]       mem_addr_o;
    logic [L-1:0]       mem_wdata_o;
    logic               mem_wren_o;
    logic [L-1:0]       mem_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dut_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    vector_mem_sequencer #(.L(L), .A(A), .LANES(LANES)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .is_store_i  (is_store_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .vec_data_i  (vec_data_i),
        .vec_data_o  (vec_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wren_o  (mem_wren_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] rd_dut(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] step_of(input logic [15:0] s);
`ifdef VMS_STRIDE_EN
        return {16'h0, s};
`else
        return (s == s) ? 32'd1 : 32'd1;
`endif
    endfunction

    // Negedge-clocked memory: write on the falling edge, read data presented
    // for the following rising edge.
    always @(negedge CLK) begin
        if (mem_wren_o) dut_mem[mem_addr_o] = mem_wdata_o;
        mem_rdata_i = rd_dut(mem_addr_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command end to end; expectations come from the lane model.
    task automatic run_cmd(input logic st, input logic [31:0] base, input logic [15:0] stride,
                           input logic [63:0] vec, input bit hold, output logic [63:0] got);
        logic [31:0] exp_addr [LANES];
        logic [63:0] exp_vec;
        logic [31:0] step;
        step = step_of(stride);
        exp_vec = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            exp_addr[k] = base + 32'(k) * step;
            exp_vec[k*8 +: 8] = rd_ref(exp_addr[k]);
        end
        got = '0;
        @(negedge CLK);
        start_i = 1'b1; is_store_i = st; base_addr_i = base; stride_i = stride; vec_data_i = vec;
        @(posedge CLK);
        #1;
        if (!hold) start_i = 1'b0;
        base_addr_i = $urandom; stride_i = 16'($urandom); vec_data_i = {$urandom, $urandom};
        is_store_i = ~st;
        for (int c = 1; c <= int'(LANES) + 3; c++) begin
            @(negedge CLK);
            if (c <= int'(LANES)) begin
                check($sformatf("addr[%0d]", c - 1), 64'(mem_addr_o), 64'(exp_addr[c-1]));
                check($sformatf("wren[%0d]", c - 1), 64'(mem_wren_o), 64'(st));
                if (st) check($sformatf("wdata[%0d]", c - 1), 64'(mem_wdata_o), 64'(vec[(c-1)*8 +: 8]));
                check($sformatf("busy[%0d]", c), 64'(busy_o), 64'd1);
                check($sformatf("done_early[%0d]", c), 64'(done_o), 64'd0);
            end else if (c == int'(LANES) + 1) begin
                check("done_pulse", 64'(done_o), 64'd1);
                check("busy_done", 64'(busy_o), 64'd1);
                check("wren_done", 64'(mem_wren_o), 64'd0);
                if (!st) check("load_vec", vec_data_o, exp_vec);
                got = vec_data_o;
            end else begin
                check($sformatf("done_after[%0d]", c), 64'(done_o), 64'd0);
                check($sformatf("busy_after[%0d]", c), 64'(busy_o), 64'd0);
            end
            if (hold) begin
                if (c == int'(LANES)) start_i = 1'b0;
                else if (c == int'(LANES) + 1) start_i = 1'b1;
                else if (c == int'(LANES) + 2) start_i = 1'b0;
            end
        end
        if (st) begin
            for (int k = 0; k < int'(LANES); k++) ref_mem[exp_addr[k]] = vec[k*8 +: 8];
            for (int k = 0; k < int'(LANES); k++)
                check($sformatf("mem[%0h]", exp_addr[k]), 64'(rd_dut(exp_addr[k])), 64'(rd_ref(exp_addr[k])));
        end
    endtask

    initial begin
        logic [63:0] got;
        logic [31:0] b;
        logic [63:0] v;

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_vec", vec_data_o, 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_wren", 64'(mem_wren_o), 64'd0);
        check("rst_wdata", 64'(mem_wdata_o), 64'd0);

        // Unit-stride load of a known byte pattern.
        for (int k = 0; k < 8; k++) begin
            dut_mem[32'h0001_0000 + 32'(k)] = 8'h10 + 8'(k);
            ref_mem[32'h0001_0000 + 32'(k)] = 8'h10 + 8'(k);
        end
        run_cmd(1'b0, 32'h0001_0000, 16'd1, 64'h0, 1'b0, got);
        check("load_const", got, 64'h1716151413121110);

        // Store then read back.
        run_cmd(1'b1, 32'h0002_0004, 16'd1, 64'h8877665544332211, 1'b0, got);
        run_cmd(1'b0, 32'h0002_0004, 16'd1, 64'h0, 1'b0, got);
        check("readback", got, 64'h8877665544332211);

        // Strided access and address wrap.
        run_cmd(1'b0, 32'h0000_0100, 16'd4, 64'h0, 1'b0, got);
        run_cmd(1'b0, 32'hFFFF_FFFE, 16'd1, 64'h0, 1'b0, got);

        // start_i held through a transfer and pulsed in DONE: one transfer only.
        run_cmd(1'b0, 32'h0000_0400, 16'd1, 64'h0, 1'b1, got);

        // Reset in the 4th transfer cycle of a store.
        b = 32'h0000_3000;
        v = 64'hA1B2C3D4E5F60718;
        @(negedge CLK);
        start_i = 1'b1; is_store_i = 1'b1; base_addr_i = b; stride_i = 16'd1; vec_data_i = v;
        @(posedge CLK);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2;
        check("wren_pre_rst", 64'(mem_wren_o), 64'd1);
        RST = 1'b1;
        #1;
        check("wren_async_rst", 64'(mem_wren_o), 64'd0);
        check("busy_async_rst", 64'(busy_o), 64'd0);
        check("done_async_rst", 64'(done_o), 64'd0);
        for (int k = 0; k < 3; k++) ref_mem[b + 32'(k) * step_of(16'd1)] = v[k*8 +: 8];
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            check($sformatf("no_done_after_rst[%0d]", c), 64'(done_o), 64'd0);
        end
        run_cmd(1'b0, b, 16'd1, 64'h0, 1'b0, got);

        // Randomized mix of loads and stores over a small address window.
        for (int t = 0; t < 24; t++) begin
            b = (t % 3 == 0) ? $urandom : (32'h0005_0000 + 32'($urandom_range(0, 64)));
            v = {$urandom, $urandom};
            run_cmd(1'($urandom_range(0, 1)), b, 16'($urandom_range(0, 16)), v, 1'b0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
